sha256_block_padder: RTL and testbench
======================================

# sha256_block_padder

Streaming front end for the SHA-256 datapath. Accepts the raw message as a valid/ready stream of 32-bit words and emits complete 512-bit blocks as a stream of 16 words each. The last block carries the `0x80000000` pad word, zero fill and the 64-bit message bit length. It sits directly upstream of the compression/message-schedule core, so that core only ever sees whole, already-padded blocks.

## Interface
- `LEN_W`, default 16: width of the message length in words.
- `clk`, input, 1: clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle pulse; captures `msg_words` and begins a message. Ignored while `busy`.
- `msg_words`, input, `LEN_W`: message length L in 32-bit words (0 allowed).
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse after the final length word is accepted downstream.
- `in_valid`, input, 1 / `in_ready`, output, 1 / `in_data`, input, 32: message word stream.
- `out_valid`, output, 1 / `out_ready`, input, 1 / `out_data`, output, 32: padded word stream.
- `out_idx`, output, 4: word index within the current block (0..15).
- `out_block_last`, output, 1: high on `out_idx == 15`.
- `out_msg_last`, output, 1: high on the final word of the final block.

## Operation
- States: IDLE, MSG, PAD, ZERO, LEN_HI, LEN_LO, FIN.
- Each state produces one output word per accepted output slot.
- Transitions:
  - IDLE→MSG on `start` when L>0.
  - IDLE→PAD on `start` when L=0.
  - MSG→PAD after the L-th input word is accepted.
  - PAD→ZERO, or PAD→LEN_HI if the next `out_idx` is 14.
  - ZERO→LEN_HI when the next `out_idx` is 14.
  - LEN_HI→LEN_LO→FIN→IDLE.
- MSG: `in_data` is forwarded unchanged.
- PAD: emits `32'h80000000`.
- ZERO: emits `32'h0`.
- LEN_HI: emits bits [63:32] of the bit length.
- LEN_LO: emits bits [31:0] of the bit length.
- Bit length = {L, 5'b0}, zero-extended to 64 bits. LEN_HI is 0 for `LEN_W` ≤ 27.
- `out_idx` is 4 bits, increments on every output handshake and wraps 15→0.
- The PAD word may land on index 14 or 15. It then forces a full extra block of zeros before the length words; L mod 16 ∈ {14, 15} yields that extra block.
- Block count = floor((L+2)/16)+1.
- Input words arriving in any state other than MSG are not accepted (`in_ready` low).
- A `start` while `busy` has no effect; the captured L is unchanged.

## Timing
- Reset values:
  - `busy`, `done`, `out_valid`, `in_ready`, `out_block_last`, `out_msg_last` = 0.
  - `out_data` = 0, `out_idx` = 0.
  - State = IDLE.
- Output register: one-entry valid/ready stage. Loads when `!out_valid || out_ready`.
- Latency: input handshake at cycle n → `out_valid` with that word at cycle n+1. Full throughput: 1 word/cycle with `out_ready` held high.
- `in_ready` = (state==MSG) && (`!out_valid || out_ready`). No combinational path `in_valid` → `out_valid`.
- While `out_valid && !out_ready`, `out_data`, `out_idx` and both last flags hold stable.
- Padding words are generated back-to-back with no idle cycles.
- `done` is asserted in the cycle after the LEN_LO handshake. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle `done` is high.
- Reset mid-message: everything returns to reset values immediately. Partial blocks are discarded and no `done` is issued.

## Configuration
- `SHA256_PADDER_LEN_CHECK_EN` defined:
  - Adds input `in_last` (1) and output `len_err` (1).
  - `len_err` sets (sticky) if `in_last` is high on an accepted word other than the L-th, or low on the L-th.
  - `len_err` clears on accepted `start`.
  - Padding always follows `msg_words`, regardless of `in_last`.
- `SHA256_PADDER_LEN_CHECK_EN` undefined: neither port exists and no check logic is built.

## Structure
- `sha256_pkg` holds:
  - the state enum typedef;
  - `SHA256_PAD_WORD = 32'h80000000`;
  - `SHA256_BLOCK_WORDS = 16`;
  - function `sha256_num_blocks(L)` = floor((L+2)/16)+1, shared with the compression core.
- Sub-module `sha256_out_reg`: the one-entry valid/ready output register, carrying data, idx and both last flags.

## Test plan
- L=0 → one block: word0=`80000000`, words1–15=0, `out_msg_last` on word15, `done` one cycle later.
- L=20, words 1..20 → block0 = words 1..16. Block1: words 17..20, idx4=`80000000`, idx5–13=0, idx14=0, idx15=`00000280`.
- L=14 → two blocks: block0 idx14=`80000000`, idx15=0. Block1 idx0–14=0, idx15=`000001C0`.
- L=16 → block1: idx0=`80000000`, idx15=`00000200`.
- L=20 with `out_ready` toggling pseudo-randomly and `in_valid` gaps → output sequence identical to the unstalled run, no drops or duplicates, fields stable while stalled.
- Reset asserted at input word 9 of L=20, then `start` with L=0 → clean single-block output. With `SHA256_PADDER_LEN_CHECK_EN`: `in_last` on word 19 of L=20 → `len_err`=1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, padding constants and block-count helper.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MSG,
    ST_PAD,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_FIN
  } sha256_state_e;

  localparam logic [31:0] SHA256_PAD_WORD    = 32'h8000_0000;
  localparam int          SHA256_BLOCK_WORDS = 16;

  // Blocks needed for L message words: pad word plus two length words must fit.
  function automatic int unsigned sha256_num_blocks(input int unsigned l);
    return (l + 32'd2) / 32'd16 + 32'd1;
  endfunction

endpackage

// File: rtl/sha256_out_reg.sv
// One-entry valid/ready output stage carrying data, block index and last flags.
// Loads whenever empty or being drained; fields hold while stalled (out_valid && !out_ready).
module sha256_out_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic [3:0]  load_idx,
  input  logic        load_block_last,
  input  logic        load_msg_last,
  output logic        load_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_block_last,
  output logic        out_msg_last
);

  assign load_en = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_idx        <= '0;
      out_block_last <= 1'b0;
      out_msg_last   <= 1'b0;
    end else if (load_en) begin
      out_valid <= load_valid;
      if (load_valid) begin
        out_data       <= load_data;
        out_idx        <= load_idx;
        out_block_last <= load_block_last;
        out_msg_last   <= load_msg_last;
      end
    end
  end

endmodule

// File: rtl/sha256_block_padder.sv
// Streams a message of L words into padded 512-bit blocks (16 words), one registered stage of latency.
// Optional length check on in_last built when SHA256_PADDER_LEN_CHECK_EN is defined.
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_words,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
`ifdef SHA256_PADDER_LEN_CHECK_EN
  input  logic             in_last,
  output logic             len_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_idx,
  output logic             out_block_last,
  output logic             out_msg_last
);

  localparam int IDX_W = $clog2(SHA256_BLOCK_WORDS);

  sha256_state_e    state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remain;
  logic [IDX_W-1:0] gen_idx;
  logic [IDX_W-1:0] idx_inc;
  logic             gen_valid;
  logic [31:0]      gen_data;
  logic             load_en;
  logic             start_acc;
  logic             in_fire;
  logic             done_q;
  logic [63:0]      len_bits;

  assign len_bits  = {{(64-LEN_W){1'b0}}, len_q} << 5;
  assign start_acc = start && (state == ST_IDLE);
  assign in_ready  = (state == ST_MSG) && load_en;
  assign in_fire   = in_valid && in_ready;
  assign idx_inc   = gen_idx + IDX_W'(1);
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gen_valid = 1'b0;
    gen_data  = '0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (msg_words == '0) ? ST_PAD : ST_MSG;
      end
      ST_MSG: begin
        gen_valid = in_valid;
        gen_data  = in_data;
        if (in_fire && remain == LEN_W'(1)) state_nxt = ST_PAD;
      end
      ST_PAD: begin
        gen_valid = 1'b1;
        gen_data  = SHA256_PAD_WORD;
        if (load_en) state_nxt = (idx_inc == IDX_W'(14)) ? ST_LEN_HI : ST_ZERO;
      end
      ST_ZERO: begin
        gen_valid = 1'b1;
        if (load_en && idx_inc == IDX_W'(14)) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        gen_valid = 1'b1;
        gen_data  = len_bits[63:32];
        if (load_en) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        gen_valid = 1'b1;
        gen_data  = len_bits[31:0];
        if (load_en) state_nxt = ST_FIN;
      end
      // Hold until the length word has left the output stage.
      ST_FIN: begin
        if (out_valid && out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q   <= '0;
      remain  <= '0;
      gen_idx <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == ST_FIN) && out_valid && out_ready;
      if (start_acc) begin
        len_q   <= msg_words;
        remain  <= msg_words;
        gen_idx <= '0;
      end
      if (gen_valid && load_en) gen_idx <= idx_inc;
      if (in_fire) remain <= remain - LEN_W'(1);
    end
  end

`ifdef SHA256_PADDER_LEN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     len_err <= 1'b0;
    else if (start_acc)                               len_err <= 1'b0;
    else if (in_fire && (in_last != (remain == LEN_W'(1)))) len_err <= 1'b1;
  end
`endif

  sha256_out_reg u_out_reg (
    .clk             (clk),
    .reset_n         (reset_n),
    .load_valid      (gen_valid),
    .load_data       (gen_data),
    .load_idx        (gen_idx),
    .load_block_last (gen_idx == IDX_W'(15)),
    .load_msg_last   (state == ST_LEN_LO),
    .load_en         (load_en),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_idx         (out_idx),
    .out_block_last  (out_block_last),
    .out_msg_last    (out_msg_last)
  );

endmodule

// File: tb/tb_sha256_block_padder.sv
// Scoreboard bench for sha256_block_padder: expected padded words queued at stimulus, popped at output.
module tb_sha256_block_padder;
  import sha256_pkg::*;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_words = '0;
  logic             busy, done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             len_err;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [3:0]       out_idx;
  logic             out_block_last, out_msg_last;

  sha256_block_padder #(.LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .msg_words      (msg_words),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
`ifdef SHA256_PADDER_LEN_CHECK_EN
    .in_last        (in_last),
    .len_err        (len_err),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .out_block_last (out_block_last),
    .out_msg_last   (out_msg_last)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_done_cyc = -1;
  bit          stall_mode = 1'b0;
  bit          lat_chk = 1'b0;
  logic        lat_pend = 1'b0;
  logic [31:0] lat_word = '0;
  logic [37:0] sb_q[$];
  logic [37:0] sb_exp;

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (lat_chk && lat_pend) tb_check("latency", {out_valid, out_data}, {1'b1, lat_word});
      lat_pend = in_valid && in_ready;
      lat_word = in_data;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tb_check("extra_word", {out_idx, out_data}, 64'hDEAD);
        end else begin
          sb_exp = sb_q.pop_front();
          tb_check("out_word", {out_msg_last, out_block_last, out_idx, out_data}, sb_exp);
        end
        if (out_msg_last) exp_done_cyc = cyc + 1;
      end
    end else begin
      lat_pend = 1'b0;
    end
  end

  task automatic push_exp(input int n, input logic [31:0] w, input logic ml);
    sb_q.push_back({ml, 1'((n % 16) == 15), 4'(n % 16), w});
  endtask

  task automatic reset_and_check();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    start     = 1'b0;
    #1;
    sb_q.delete();
    tb_check("rst_busy",  busy, 0);
    tb_check("rst_done",  done, 0);
    tb_check("rst_oval",  out_valid, 0);
    tb_check("rst_irdy",  in_ready, 0);
    tb_check("rst_flags", {out_block_last, out_msg_last}, 0);
    tb_check("rst_data",  {out_idx, out_data}, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives one message of words base+1..base+len; abort_at resets after that word index.
  task automatic run_msg(input int len, input int base, input bit gaps,
                         input int abort_at, input int last_err_at);
    int n;
    int tmo;
    n = 0;
    for (int i = 0; i < len; i++) begin
      push_exp(n, 32'(base + i + 1), 1'b0);
      n++;
    end
    push_exp(n, 32'h8000_0000, 1'b0);
    n++;
    while ((n % 16) != 14) begin
      push_exp(n, 32'h0, 1'b0);
      n++;
    end
    push_exp(n, 32'h0, 1'b0);
    n++;
    push_exp(n, 32'(len * 32), 1'b1);
    n++;
    tb_check("num_blocks", n, 16 * sha256_num_blocks(len));
    exp_done_cyc = -1;

    start = 1'b1;
    msg_words = LEN_W'(len);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    tb_check("busy_after_start", busy, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = 32'(base + i + 1);
      in_last  = (i == len - 1) ^ (i == last_err_at);
      if (i == 3) begin
        start     = 1'b1;
        msg_words = LEN_W'(3);
      end
      tmo = 0;
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        tmo++;
        if (tmo > 200) begin
          tb_check("in_ready_timeout", 0, 1);
          break;
        end
        @(posedge clk);
        #1 start = 1'b0;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (i == abort_at) begin
        reset_and_check();
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    tmo = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      tmo++;
      if (tmo > 3000) begin
        tb_check("done_timeout", 0, 1);
        break;
      end
    end
    if (done) begin
      tb_check("done_cycle", cyc, exp_done_cyc);
      tb_check("sb_drained", sb_q.size(), 0);
      tb_check("busy_at_done", busy, 0);
      @(negedge clk);
      tb_check("done_pulse", done, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_and_check();

    lat_chk = 1'b1;
    run_msg(0, 0, 1'b0, -1, -1);
    run_msg(20, 0, 1'b0, -1, -1);
    run_msg(14, 100, 1'b0, -1, -1);
    run_msg(16, 200, 1'b0, -1, -1);
    run_msg(15, 300, 1'b0, -1, -1);
    lat_chk = 1'b0;

    stall_mode = 1'b1;
    run_msg(20, 0, 1'b1, -1, -1);
    run_msg(31, 500, 1'b1, -1, -1);
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    run_msg(20, 0, 1'b0, 8, -1);
    run_msg(0, 0, 1'b0, -1, -1);

`ifdef SHA256_PADDER_LEN_CHECK_EN
    run_msg(20, 0, 1'b0, -1, 18);
    tb_check("len_err_set", len_err, 1);
    run_msg(5, 40, 1'b0, -1, -1);
    tb_check("len_err_clear", len_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
